// File: rtl/prio_arbiter.sv
// Eight-requester arbiter with registered one-hot grant, fixed or round-robin
// priority, a hold limit per grant and one mandatory idle cycle between grants.
module prio_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       rr_mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    // Highest set index wins, matching the 8:3 priority encoder ordering.
    function automatic logic [2:0] fixed_pick(input logic [7:0] r);
        logic [2:0] w;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w = r[i] ? 3'(i) : w;
        end
        return w;
    endfunction

    // First set bit searching downward from p, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] w;
        logic [2:0] idx;
        logic       found;
        w     = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx   = p - 3'(k);
            w     = (!found && r[idx]) ? idx : w;
            found = found | r[idx];
        end
        return w;
    endfunction

    state_t            state_r, state_s;
    logic [7:0]        gnt_r, gnt_s;
    logic [2:0]        gnt_id_r, gnt_id_s;
    logic              valid_r, valid_s;
    logic [2:0]        ptr_r, ptr_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic [2:0]        win_s;
    logic              release_s;

    // Next-state, winner selection and release evaluation.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        gnt_id_s  = gnt_id_r;
        valid_s   = valid_r;
        ptr_s     = ptr_r;
        hold_s    = hold_r;
        win_s     = rr_mode ? rr_pick(req, ptr_r) : fixed_pick(req);
        release_s = !en || !req[gnt_id_r] || (HOLD_EN && (hold_r == HOLD_LAST));
        case (state_r)
            IDLE: begin
                if (en && (req != 8'h00)) begin
                    gnt_s    = 8'h01 << win_s;
                    gnt_id_s = win_s;
                    valid_s  = 1'b1;
                    hold_s   = {HOLD_W{1'b0}};
                    state_s  = GRANT;
                    // The winner drops to lowest priority for the next decision.
                    ptr_s    = rr_mode ? (win_s - 3'd1) : ptr_r;
                end else begin
                    gnt_s   = 8'h00;
                    valid_s = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    gnt_s   = 8'h00;
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    hold_s  = hold_r + HOLD_ONE;
                end
            end
            default: begin
                gnt_s   = 8'h00;
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            gnt_r    <= 8'h00;
            gnt_id_r <= 3'd0;
            valid_r  <= 1'b0;
            ptr_r    <= 3'd7;
            hold_r   <= {HOLD_W{1'b0}};
        end else begin
            state_r  <= state_s;
            gnt_r    <= gnt_s;
            gnt_id_r <= gnt_id_s;
            valid_r  <= valid_s;
            ptr_r    <= ptr_s;
            hold_r   <= hold_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = valid_r;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter: vector table plus hand-written sequences
// for round-robin rotation, mid-grant reset and rr_mode changes.
module tb_prio_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rr_mode;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    int checks;
    int errors;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       rr;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
    } vec_t;

    vec_t vecs [21];

    prio_arbiter #(.MAX_HOLD(4), .HOLD_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rr_mode   (rr_mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic m, input logic [7:0] q,
                        input logic [7:0] xg, input logic [2:0] xi, input logic xv,
                        input string name);
        rst_n   = r;
        en      = e;
        rr_mode = m;
        req     = q;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== xg || gnt_id !== xi || gnt_valid !== xv) begin
            errors++;
            $display("FAIL %s: got gnt=%h id=%0d valid=%b, expected gnt=%h id=%0d valid=%b",
                     name, gnt, gnt_id, gnt_valid, xg, xi, xv);
        end
    endtask

    initial begin
        logic [2:0] eid;
        logic       ev;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        rr_mode = 1'b0;
        req     = 8'hFF;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h80, 3'd7, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h24, 8'h00, 3'd7, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h24, 8'h20, 3'd5, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h00, 3'd5, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h04, 3'd2, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd2, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h00, 3'd7, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h80, 3'd7, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 3'd7, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h00, 3'd7, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h08, 8'h08, 3'd3, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 3'd3, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 1'b0, 8'h08, 8'h00, 3'd3, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 3'd3, 1'b0};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].rr, vecs[i].req,
                 vecs[i].gnt, vecs[i].id, vecs[i].valid, $sformatf("vec%0d", i));
        end

        // Round-robin rotation with all requesters pending: 4 grant cycles, 1 gap.
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "rr_reset");
        for (int c = 0; c < 22; c++) begin
            eid = 3'd7 - 3'(c / 5);
            ev  = ((c % 5) != 4);
            step(1'b1, 1'b1, 1'b1, 8'hFF, ev ? (8'h01 << eid) : 8'h00, eid, ev,
                 $sformatf("rr_cycle%0d", c));
        end

        // Reset in the middle of the grant to id 3; pointer must return to 7.
        step(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, "midgrant_reset");
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'h80, 3'd7, 1'b1, "post_reset_ptr");

        // rr_mode toggled while id 6 is held; new mode applies at the next decision.
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, "mode_reset");
        step(1'b1, 1'b1, 1'b1, 8'h40, 8'h40, 3'd6, 1'b1, "mode_grant6");
        step(1'b1, 1'b1, 1'b0, 8'h40, 8'h40, 3'd6, 1'b1, "mode_toggle_hold");
        step(1'b1, 1'b1, 1'b0, 8'hC0, 8'h40, 3'd6, 1'b1, "mode_nonowner_ignored");
        step(1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 3'd6, 1'b0, "mode_release");
        step(1'b1, 1'b1, 1'b0, 8'hC0, 8'h80, 3'd7, 1'b1, "mode_fixed_decision");
        step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd7, 1'b0, "mode_release2");
        step(1'b1, 1'b1, 1'b1, 8'hC1, 8'h01, 3'd0, 1'b1, "mode_rr_ptr5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
